// File: rtl/updi_pkg.sv
// Shared types for the UPDI PHY arbitration slice.
package updi_pkg;

  localparam int unsigned N_UPDI_REQ = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_DRAIN
  } arb_state_t;

endpackage

// File: rtl/updi_idle_watchdog.sv
// Owner-inactivity counter; expired_o flags the last idle cycle before a forced revoke.
module updi_idle_watchdog
  import updi_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT_CLKS = 50000000,
  parameter int unsigned TIMEOUT_BITS      = $clog2(IDLE_TIMEOUT_CLKS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic kick_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_BITS-1:0] LAST = TIMEOUT_BITS'(IDLE_TIMEOUT_CLKS - 1);

  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && !kick_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + TIMEOUT_BITS'(1);
    if (!en_i || kick_i || expired_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/updi_phy_arbiter.sv
// Session-level arbiter sharing one updi_phy between the programmer (port 0) and a debug bridge (port 1).
module updi_phy_arbiter
  import updi_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT_CLKS = 50000000,
  parameter int unsigned TIMEOUT_BITS      = $clog2(IDLE_TIMEOUT_CLKS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_UPDI_REQ-1:0]          req_i,
  output logic [N_UPDI_REQ-1:0]          gnt_o,
  output logic                           owner_o,
  output logic                           timeout_err_o,
  input  logic [N_UPDI_REQ-1:0][7:0]     req_tx_data_i,
  input  logic [N_UPDI_REQ-1:0]          req_tx_wr_en_i,
  output logic [N_UPDI_REQ-1:0]          req_tx_full_o,
  output logic [7:0]                     req_rx_data_o,
  input  logic [N_UPDI_REQ-1:0]          req_rx_rd_en_i,
  output logic [N_UPDI_REQ-1:0]          req_rx_empty_o,
  input  logic [N_UPDI_REQ-1:0]          req_db_start_i,
  output logic [N_UPDI_REQ-1:0]          req_db_busy_o,
  output logic [N_UPDI_REQ-1:0]          req_db_done_o,
  output logic [7:0]                     phy_tx_data_o,
  output logic                           phy_tx_wr_en_o,
  input  logic                           phy_tx_full_i,
  input  logic [7:0]                     phy_rx_data_i,
  output logic                           phy_rx_rd_en_o,
  input  logic                           phy_rx_empty_i,
  output logic                           phy_db_start_o,
  input  logic                           phy_db_busy_i,
  input  logic                           phy_db_done_i
);

  arb_state_t            state_q;
  logic [N_UPDI_REQ-1:0] gnt_q;
  logic [N_UPDI_REQ-1:0] mask_q;
  logic                  owner_q;
  logic                  timeout_q;

  logic [N_UPDI_REQ-1:0] eff_req;
  logic                  grant_idx;
  logic                  owner_kick;
  logic                  wd_expired;

  // Round-robin only matters on a tie: the previous owner yields.
  always_comb begin
    eff_req   = req_i & ~mask_q;
    grant_idx = (eff_req == 2'b11) ? ~owner_q : eff_req[1];
  end

  assign owner_kick = req_tx_wr_en_i[owner_q] | req_rx_rd_en_i[owner_q] |
                      req_db_start_i[owner_q] | phy_db_busy_i;

  updi_idle_watchdog #(
    .IDLE_TIMEOUT_CLKS (IDLE_TIMEOUT_CLKS),
    .TIMEOUT_BITS      (TIMEOUT_BITS)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == ARB_GRANT),
    .kick_i    (owner_kick),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      mask_q    <= '0;
      owner_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      mask_q    <= mask_q & req_i;
      case (state_q)
        ARB_IDLE: begin
          if (eff_req != '0) begin
            owner_q <= grant_idx;
            gnt_q   <= grant_idx ? 2'b10 : 2'b01;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (wd_expired) begin
            gnt_q           <= '0;
            timeout_q       <= 1'b1;
            mask_q[owner_q] <= 1'b1;
            state_q         <= ARB_DRAIN;
          end else if (!req_i[owner_q]) begin
            gnt_q   <= '0;
            state_q <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (phy_rx_empty_i && !phy_db_busy_i) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Only the owner in GRANT reaches the PHY; everyone else sees a stalled, quiet PHY.
  always_comb begin
    phy_tx_data_o  = '0;
    phy_tx_wr_en_o = 1'b0;
    phy_rx_rd_en_o = 1'b0;
    phy_db_start_o = 1'b0;
    req_tx_full_o  = '1;
    req_rx_empty_o = '1;
    req_db_busy_o  = '0;
    req_db_done_o  = '0;
    if (state_q == ARB_GRANT) begin
      phy_tx_data_o           = req_tx_data_i[owner_q];
      phy_tx_wr_en_o          = req_tx_wr_en_i[owner_q];
      phy_rx_rd_en_o          = req_rx_rd_en_i[owner_q];
      phy_db_start_o          = req_db_start_i[owner_q];
      req_tx_full_o[owner_q]  = phy_tx_full_i;
      req_rx_empty_o[owner_q] = phy_rx_empty_i;
      req_db_busy_o[owner_q]  = phy_db_busy_i;
      req_db_done_o[owner_q]  = phy_db_done_i;
    end else if (state_q == ARB_DRAIN) begin
      phy_rx_rd_en_o = !phy_rx_empty_i;
    end
  end

  assign req_rx_data_o = phy_rx_data_i;
  assign gnt_o         = gnt_q;
  assign owner_o       = owner_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_updi_phy_arbiter.sv
// Self-checking bench for updi_phy_arbiter: directed scenarios plus randomized traffic against a session-level model.
module tb_updi_phy_arbiter;

  localparam int unsigned T = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req = '0;
  logic [1:0]      gnt;
  logic            owner;
  logic            timeout_err;
  logic [1:0][7:0] req_tx_data = '0;
  logic [1:0]      req_tx_wr_en = '0;
  logic [1:0]      req_tx_full;
  logic [7:0]      req_rx_data;
  logic [1:0]      req_rx_rd_en = '0;
  logic [1:0]      req_rx_empty;
  logic [1:0]      req_db_start = '0;
  logic [1:0]      req_db_busy;
  logic [1:0]      req_db_done;
  logic [7:0]      phy_tx_data;
  logic            phy_tx_wr_en;
  logic            phy_tx_full = 1'b0;
  logic [7:0]      phy_rx_data = '0;
  logic            phy_rx_rd_en;
  logic            phy_rx_empty = 1'b1;
  logic            phy_db_start;
  logic            phy_db_busy = 1'b0;
  logic            phy_db_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  updi_phy_arbiter #(.IDLE_TIMEOUT_CLKS(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .gnt_o          (gnt),
    .owner_o        (owner),
    .timeout_err_o  (timeout_err),
    .req_tx_data_i  (req_tx_data),
    .req_tx_wr_en_i (req_tx_wr_en),
    .req_tx_full_o  (req_tx_full),
    .req_rx_data_o  (req_rx_data),
    .req_rx_rd_en_i (req_rx_rd_en),
    .req_rx_empty_o (req_rx_empty),
    .req_db_start_i (req_db_start),
    .req_db_busy_o  (req_db_busy),
    .req_db_done_o  (req_db_done),
    .phy_tx_data_o  (phy_tx_data),
    .phy_tx_wr_en_o (phy_tx_wr_en),
    .phy_tx_full_i  (phy_tx_full),
    .phy_rx_data_i  (phy_rx_data),
    .phy_rx_rd_en_o (phy_rx_rd_en),
    .phy_rx_empty_i (phy_rx_empty),
    .phy_db_start_o (phy_db_start),
    .phy_db_busy_i  (phy_db_busy),
    .phy_db_done_i  (phy_db_done)
  );

  always #5 clk = ~clk;

  // Session-level reference: phase 0 = free, 1 = session owned, 2 = cleaning up.
  int         m_phase = 0;
  logic       m_owner = 1'b0;
  logic [1:0] m_gnt   = '0;
  logic [1:0] m_block = '0;
  int         m_quiet = 0;
  logic       m_to    = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    logic [1:0] want;
    logic [1:0] nblock;
    logic       who;
    logic       active;
    if (rst) begin
      m_phase <= 0; m_owner <= 1'b0; m_gnt <= '0; m_block <= '0; m_quiet <= 0; m_to <= 1'b0;
    end else begin
      m_to   <= 1'b0;
      nblock = m_block & req;
      if (m_phase == 0) begin
        m_quiet <= 0;
        want = req & ~m_block;
        if (want != 2'b00) begin
          if (want == 2'b11) who = !m_owner;
          else               who = (want == 2'b10);
          m_owner <= who;
          m_gnt   <= (who ? 2'b10 : 2'b01);
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        active = req_tx_wr_en[m_owner] || req_rx_rd_en[m_owner] || req_db_start[m_owner] || phy_db_busy;
        if (!active && m_quiet == int'(T) - 1) begin
          m_to <= 1'b1; m_gnt <= '0; m_phase <= 2;
          nblock[m_owner] = 1'b1;
        end else if (!req[m_owner]) begin
          m_gnt <= '0; m_phase <= 2;
        end
        m_quiet <= active ? 0 : m_quiet + 1;
      end else begin
        m_quiet <= 0;
        if (phy_rx_empty && !phy_db_busy) m_phase <= 0;
      end
      m_block <= nblock;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic quiet_inputs;
    req = '0; req_tx_wr_en = '0; req_rx_rd_en = '0; req_db_start = '0;
    req_tx_data = '0; phy_tx_full = 1'b0; phy_rx_empty = 1'b1;
    phy_db_busy = 1'b0; phy_db_done = 1'b0;
  endtask

  task automatic do_reset;
    quiet_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
    n_cmp++; if (owner !== 1'b0) begin n_bad++; $display("FAIL rst_owner got=%b exp=0", owner); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_timeout got=%b exp=0", timeout_err); end
    n_cmp++; if (req_tx_full !== 2'b11 || req_rx_empty !== 2'b11) begin
      n_bad++; $display("FAIL rst_views full=%b empty=%b exp=11/11", req_tx_full, req_rx_empty); end
    n_cmp++; if (req_db_busy !== 2'b00 || req_db_done !== 2'b00) begin
      n_bad++; $display("FAIL rst_db busy=%b done=%b exp=00/00", req_db_busy, req_db_done); end
    n_cmp++; if ({phy_tx_wr_en, phy_rx_rd_en, phy_db_start} !== 3'b000 || phy_tx_data !== 8'h00) begin
      n_bad++; $display("FAIL rst_phy strobes=%b data=%h exp=000/00",
                        {phy_tx_wr_en, phy_rx_rd_en, phy_db_start}, phy_tx_data); end
  endtask

  task automatic test_basic_grant;
    do_reset();
    req = 2'b01;
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL basic_gnt got=%b exp=01", gnt); end
    req_tx_data[0] = 8'h55; req_tx_data[1] = 8'hAA; req_tx_wr_en = 2'b11;
    #1;
    n_cmp++; if (phy_tx_wr_en !== 1'b1 || phy_tx_data !== 8'h55) begin
      n_bad++; $display("FAIL basic_tx wr=%b data=%h exp=1/55", phy_tx_wr_en, phy_tx_data); end
    n_cmp++; if (req_tx_full !== 2'b10 || req_rx_empty !== 2'b11) begin
      n_bad++; $display("FAIL basic_views full=%b empty=%b exp=10/11", req_tx_full, req_rx_empty); end
    req_tx_wr_en = '0; req = '0;
    tick(); tick();
  endtask

  task automatic test_round_robin;
    do_reset();
    req = 2'b11;
    tick();
    n_cmp++; if (gnt !== 2'b10 || owner !== 1'b1) begin
      n_bad++; $display("FAIL rr_first gnt=%b owner=%b exp=10/1", gnt, owner); end
    req = 2'b01;
    tick();
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL rr_drain gnt=%b exp=00", gnt); end
    tick();
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL rr_idle gnt=%b exp=00", gnt); end
    tick();
    n_cmp++; if (gnt !== 2'b01 || owner !== 1'b0) begin
      n_bad++; $display("FAIL rr_second gnt=%b owner=%b exp=01/0", gnt, owner); end
    req = '0; tick(); tick();
  endtask

  task automatic test_drain;
    int bytes;
    int reads;
    do_reset();
    req = 2'b01;
    tick();
    bytes = 3; reads = 0;
    phy_rx_empty = 1'b0; phy_db_busy = 1'b1;
    req = 2'b10;
    tick();
    phy_db_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      phy_rx_empty = (bytes == 0);
      #1;
      if (phy_rx_rd_en === 1'b1) begin reads++; bytes--; end
      n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL drain_gnt i=%0d got=%b exp=00", i, gnt); end
      n_cmp++; if (req_db_done !== 2'b00) begin n_bad++; $display("FAIL drain_done i=%0d got=%b exp=00", i, req_db_done); end
      tick();
    end
    phy_db_busy = 1'b0; phy_db_done = 1'b0; phy_rx_empty = (bytes == 0);
    #1;
    n_cmp++; if (phy_rx_rd_en !== 1'b0) begin n_bad++; $display("FAIL drain_rd_after got=%b exp=0", phy_rx_rd_en); end
    n_cmp++; if (reads != 3) begin n_bad++; $display("FAIL drain_reads got=%0d exp=3", reads); end
    tick();
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL drain_idle gnt=%b exp=00", gnt); end
    tick();
    n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL drain_regrant gnt=%b exp=10", gnt); end
    req = '0; tick(); tick();
  endtask

  task automatic test_timeout;
    int early;
    do_reset();
    req = 2'b01;
    tick();
    early = 0;
    for (int i = 0; i < int'(T) - 1; i++) begin
      tick();
      if (gnt !== 2'b01 || timeout_err !== 1'b0) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL to_early bad_cycles got=%0d exp=0", early); end
    tick();
    n_cmp++; if (gnt !== 2'b00 || timeout_err !== 1'b1) begin
      n_bad++; $display("FAIL to_fire gnt=%b err=%b exp=00/1", gnt, timeout_err); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse err=%b exp=0", timeout_err); end
    early = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gnt !== 2'b00) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL to_masked regrants got=%0d exp=0", early); end
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL to_regrant gnt=%b exp=01", gnt); end
    req = '0; tick(); tick();
  endtask

  task automatic test_no_timeout;
    int bad;
    do_reset();
    req = 2'b01;
    tick();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      req_tx_wr_en = {1'b0, (i % 10 == 9)};
      tick();
      if (timeout_err !== 1'b0 || gnt !== 2'b01) bad++;
    end
    req_tx_wr_en = '0;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL active_owner bad_cycles got=%0d exp=0", bad); end
    bad = 0;
    phy_db_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (timeout_err !== 1'b0 || gnt !== 2'b01) bad++;
    end
    phy_db_busy = 1'b0;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL busy_hold bad_cycles got=%0d exp=0", bad); end
    req = '0; tick(); tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    req = 2'b10;
    tick();
    phy_rx_empty = 1'b0; phy_db_busy = 1'b1; req_rx_rd_en = 2'b10;
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== 2'b00 || owner !== 1'b0) begin
      n_bad++; $display("FAIL rmid_async gnt=%b owner=%b exp=00/0", gnt, owner); end
    n_cmp++; if (phy_rx_rd_en !== 1'b0 || req_rx_empty !== 2'b11 || req_tx_full !== 2'b11) begin
      n_bad++; $display("FAIL rmid_views rd=%b empty=%b full=%b exp=0/11/11", phy_rx_rd_en, req_rx_empty, req_tx_full); end
    tick();
    n_cmp++; if (phy_rx_rd_en !== 1'b0 || gnt !== 2'b00) begin
      n_bad++; $display("FAIL rmid_hold rd=%b gnt=%b exp=0/00", phy_rx_rd_en, gnt); end
    quiet_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random;
    logic       quiet;
    logic [1:0] e_full, e_empty, e_busy, e_done;
    logic       e_wr, e_rd, e_db;
    logic [7:0] e_data;
    quiet = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 48 == 0) quiet = ($urandom_range(0, 1) == 1);
      for (int r = 0; r < 2; r++) if ($urandom_range(0, 11) == 0) req[r] = ~req[r];
      for (int r = 0; r < 2; r++) begin
        req_tx_wr_en[r] = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
        req_rx_rd_en[r] = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
        req_db_start[r] = quiet ? 1'b0 : ($urandom_range(0, 7) == 0);
        req_tx_data[r]  = 8'($urandom);
      end
      phy_tx_full  = ($urandom_range(0, 3) == 0);
      phy_rx_empty = ($urandom_range(0, 2) != 0);
      phy_db_busy  = quiet ? 1'b0 : ($urandom_range(0, 5) == 0);
      phy_db_done  = ($urandom_range(0, 3) == 0);
      phy_rx_data  = 8'($urandom);
      #1;
      e_wr = 1'b0; e_rd = 1'b0; e_db = 1'b0; e_data = '0;
      e_full = 2'b11; e_empty = 2'b11; e_busy = '0; e_done = '0;
      if (m_phase == 1) begin
        e_wr = req_tx_wr_en[m_owner]; e_rd = req_rx_rd_en[m_owner];
        e_db = req_db_start[m_owner]; e_data = req_tx_data[m_owner];
        e_full[m_owner] = phy_tx_full;  e_empty[m_owner] = phy_rx_empty;
        e_busy[m_owner] = phy_db_busy;  e_done[m_owner] = phy_db_done;
      end else if (m_phase == 2) begin
        e_rd = !phy_rx_empty;
      end
      n_cmp++; if (gnt !== m_gnt) begin n_bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, m_gnt); end
      n_cmp++; if (owner !== m_owner) begin n_bad++; $display("FAIL rnd_owner c=%0d got=%b exp=%b", c, owner, m_owner); end
      n_cmp++; if (timeout_err !== m_to) begin n_bad++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, timeout_err, m_to); end
      n_cmp++; if ({phy_tx_wr_en, phy_rx_rd_en, phy_db_start} !== {e_wr, e_rd, e_db}) begin
        n_bad++; $display("FAIL rnd_strobes c=%0d got=%b exp=%b", c,
                          {phy_tx_wr_en, phy_rx_rd_en, phy_db_start}, {e_wr, e_rd, e_db}); end
      n_cmp++; if (phy_tx_data !== e_data) begin n_bad++; $display("FAIL rnd_txdata c=%0d got=%h exp=%h", c, phy_tx_data, e_data); end
      n_cmp++; if ({req_tx_full, req_rx_empty} !== {e_full, e_empty}) begin
        n_bad++; $display("FAIL rnd_fifo_views c=%0d got=%b exp=%b", c, {req_tx_full, req_rx_empty}, {e_full, e_empty}); end
      n_cmp++; if ({req_db_busy, req_db_done} !== {e_busy, e_done}) begin
        n_bad++; $display("FAIL rnd_db_views c=%0d got=%b exp=%b", c, {req_db_busy, req_db_done}, {e_busy, e_done}); end
      tick();
    end
    quiet_inputs();
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_drain();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
